mxi_nch_pipe: RTL and testbench

Parametrised, pipelined N-channel multiplexer with selectable output inversion, used as the datapath select stage in the AES round logic. It is the successor to the single-bit 2:1 inverting mux cell, generalised to WIDTH-bit words, NCH input channels and a runtime invert/pass mode. It has a registered valid/ready handshake and an optional skid buffer so it can sit between pipeline stages without combinational ready paths.

---
 rtl/mxi_nch_pipe_if.sv | 30 +++
 rtl/mxi_nch_pipe.sv | 143 ++++++++++++++
 tb/tb_mxi_nch_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mxi_nch_pipe_if.sv
// mxi_nch_pipe_if: stream bundle for the N-channel inverting mux stage.
// Input side: in_data (NCH*WIDTH), in_sel (SELW), in_inv, in_valid, in_ready.
// Output side: out_data (WIDTH), out_valid, out_ready, plus sticky sel_err.
// master = upstream/downstream environment, slave = the mux stage.
interface mxi_nch_pipe_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_inv;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sel_err;

    modport master (
        output in_data, in_sel, in_inv, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_sel, in_inv, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/mxi_nch_pipe.sv
// mxi_nch_pipe: pipelined NCH:1 WIDTH-bit mux with runtime invert/pass mode.
// Ports: clk, rst (sync, active-high), bus (mxi_nch_pipe_if.slave).
// Define MXI_NCH_PIPE_SKID_EN for the two-entry skid buffer with registered
// in_ready; otherwise a single output register with combinational in_ready.
module mxi_nch_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input logic          clk,
    input logic          rst,
    mxi_nch_pipe_if.slave bus
);
    localparam int SELW = $clog2(NCH);
    localparam logic [SELW:0] NCH_LIM = (SELW+1)'(NCH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             sel_err_q;
    logic             bad_sel;
    logic             in_fire;
    logic             out_fire;

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        pick = bus.in_data[WIDTH-1:0];
        for (int k = 1; k < NCH; k++) begin
            if (bus.in_sel == SELW'(k)) begin
                pick = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign word     = bus.in_inv ? ~pick : pick;
    assign bad_sel  = {1'b0, bus.in_sel} >= NCH_LIM;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (in_fire && bad_sel) begin
            sel_err_q <= 1'b1;
        end
    end

`ifdef MXI_NCH_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic             ready_q;

    // out_q always holds the oldest word; skid_q the younger one in FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_q       <= word;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_q  <= word;
                        ready_q <= 1'b0;
                        state   <= FULL;
                    end else if (in_fire) begin
                        out_q <= word;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_q   <= skid_q;
                        ready_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready = ready_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_q       <= word;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire) begin
                        out_q <= word;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    // Accept when the register is free or is being emptied this cycle.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_mxi_nch_pipe.sv
// tb_mxi_nch_pipe: scoreboard bench for mxi_nch_pipe (NCH=4 and NCH=3 copies).
// Driver tasks push expected words on acceptance; negedge monitors pop them.
module tb_mxi_nch_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [7:0] q4[$];
    logic [7:0] q3[$];

    mxi_nch_pipe_if #(.WIDTH(8), .NCH(4)) bus4 ();
    mxi_nch_pipe_if #(.WIDTH(8), .NCH(3)) bus3 ();

    mxi_nch_pipe #(.WIDTH(8), .NCH(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    mxi_nch_pipe #(.WIDTH(8), .NCH(3)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL u4 out: got %0h with nothing expected",
                         bus4.out_data);
            end else begin
                logic [7:0] e;
                e = q4.pop_front();
                if (bus4.out_data !== e) begin
                    errors++;
                    $display("FAIL u4 out: got %0h expected %0h",
                             bus4.out_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus3.out_valid && bus3.out_ready) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL u3 out: got %0h with nothing expected",
                         bus3.out_data);
            end else begin
                logic [7:0] e;
                e = q3.pop_front();
                if (bus3.out_data !== e) begin
                    errors++;
                    $display("FAIL u3 out: got %0h expected %0h",
                             bus3.out_data, e);
                end
            end
        end
    end

    function automatic logic [7:0] model4(input logic [31:0] d,
                                          input logic [1:0] s,
                                          input logic inv);
        logic [7:0] w;
        w = d[s*8 +: 8];
        return inv ? ~w : w;
    endfunction

    // Offer one word to u4, bounded wait; returns at edge+1 after acceptance.
    task automatic send4(input logic [31:0] d, input logic [1:0] s,
                         input logic inv, input logic [7:0] exp);
        logic ok;
        ok = 1'b0;
        bus4.in_data  = d;
        bus4.in_sel   = s;
        bus4.in_inv   = inv;
        bus4.in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus4.in_ready) begin
                q4.push_back(exp);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL u4 send timeout: got no in_ready expected 1");
        end
    endtask

    task automatic send3(input logic [23:0] d, input logic [1:0] s,
                         input logic inv, input logic [7:0] exp);
        logic ok;
        ok = 1'b0;
        bus3.in_data  = d;
        bus3.in_sel   = s;
        bus3.in_inv   = inv;
        bus3.in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus3.in_ready) begin
                q3.push_back(exp);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus3.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL u3 send timeout: got no in_ready expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    logic [31:0] d;
    logic [1:0]  s;
    logic        inv;
    int          acc;
    logic [7:0]  bp_exp [3];
    logic [1:0]  bp_sel [3];
    logic        bp_inv [3];
    logic [7:0]  st_exp [4];

    initial begin
        bus4.in_data   = '0;
        bus4.in_sel    = '0;
        bus4.in_inv    = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        bus3.in_data   = '0;
        bus3.in_sel    = '0;
        bus3.in_inv    = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst out_valid", bus4.out_valid, 0);
        chk("rst out_data", bus4.out_data, 8'h00);
        chk("rst sel_err", bus4.sel_err, 0);
        chk("rst in_ready", bus4.in_ready, 1);
        chk("rst u3 sel_err", bus3.sel_err, 0);
        @(posedge clk);
        #1;

        // Stream: one word per cycle, visible one cycle after acceptance
        st_exp[0] = 8'h11;
        st_exp[1] = 8'h22;
        st_exp[2] = 8'h33;
        st_exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            send4(32'h44332211, 2'(i), 1'b0, st_exp[i]);
            chk("stream out_valid", bus4.out_valid, 1);
            chk("stream out_data", bus4.out_data, st_exp[i]);
        end

        // Inversion
        send4(32'h445A2211, 2'd2, 1'b1, 8'hA5);
        chk("inv on", bus4.out_data, 8'hA5);
        send4(32'h445A2211, 2'd2, 1'b0, 8'h5A);
        chk("inv off", bus4.out_data, 8'h5A);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure
        bp_sel[0] = 2'd0; bp_inv[0] = 1'b0; bp_exp[0] = 8'hA1;
        bp_sel[1] = 2'd1; bp_inv[1] = 1'b1; bp_exp[1] = 8'h4D;
        bp_sel[2] = 2'd3; bp_inv[2] = 1'b0; bp_exp[2] = 8'hD4;
        bus4.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            bus4.in_data  = 32'hD4C3B2A1;
            bus4.in_sel   = bp_sel[i];
            bus4.in_inv   = bp_inv[i];
            bus4.in_valid = 1'b1;
            @(negedge clk);
            if (i == 2) chk("bp in_ready third", bus4.in_ready, 0);
            if (bus4.in_ready) begin
                q4.push_back(bp_exp[i]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
`ifdef MXI_NCH_PIPE_SKID_EN
        chk("bp accepted", acc, 2);
`else
        chk("bp accepted", acc, 1);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp stall data", bus4.out_data, 8'hA1);
            chk("bp stall valid", bus4.out_valid, 1);
        end
        @(posedge clk);
        #1 bus4.out_ready = 1'b1;
        for (int t = 0; t < 10 && q4.size() != 0; t++) @(negedge clk);
        chk("bp drained", q4.size(), 0);
        @(posedge clk);
        #1;

        // Out-of-range select on NCH=3
        send3(24'h332211, 2'd2, 1'b0, 8'h33);
        chk("sel ok no err", bus3.sel_err, 0);
        send3(24'h332211, 2'd3, 1'b0, 8'h11);
        chk("sel bad err", bus3.sel_err, 1);
        chk("sel bad data", bus3.out_data, 8'h11);
        send3(24'h332211, 2'd1, 1'b1, 8'hDD);
        chk("sel err sticky 1", bus3.sel_err, 1);
        send3(24'h332211, 2'd0, 1'b0, 8'h11);
        chk("sel err sticky 2", bus3.sel_err, 1);
        repeat (3) @(posedge clk);
        #1;

        // Reset with stored words
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus4.in_data  = 32'h0F0E0D0C;
            bus4.in_sel   = 2'(i);
            bus4.in_inv   = 1'b0;
            bus4.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("full in_ready", bus4.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q4.delete();
        q3.delete();
        @(negedge clk);
        chk("mid rst out_valid", bus4.out_valid, 0);
        chk("mid rst out_data", bus4.out_data, 8'h00);
        chk("mid rst in_ready", bus4.in_ready, 1);
        chk("mid rst u3 sel_err", bus3.sel_err, 0);
        @(posedge clk);
        #1 bus4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no stale word", bus4.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Back-to-back random words with simultaneous transfers
        for (int i = 0; i < 16; i++) begin
            d   = $urandom;
            s   = 2'($urandom_range(0, 3));
            inv = 1'($urandom_range(0, 1));
            send4(d, s, inv, model4(d, s, inv));
            chk("rand out_valid", bus4.out_valid, 1);
        end
        for (int t = 0; t < 10 && q4.size() != 0; t++) @(negedge clk);
        chk("rand drained", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
